// File: rtl/dj8v_adc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dj8v_adc_pkg
//  Purpose  : Shared types and default constants for the dj8v SAR ADC path.
//  Contents : sar_state_e FSM encoding; default resolution, settle length
//             and comparator synchroniser depth.
//  Revision : 1.0 - initial release
// ============================================================================
package dj8v_adc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } sar_state_e;

    localparam int c_DEFAULT_WIDTH         = 8;
    localparam int c_DEFAULT_SETTLE_CYCLES = 4;
    localparam int c_DEFAULT_SYNC_STAGES   = 2;

endpackage : dj8v_adc_pkg
`default_nettype wire

// File: rtl/dj8v_cmp_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dj8v_cmp_sync
//  Purpose  : Multi-stage flip-flop synchroniser for the asynchronous
//             comparator output. All stages clear to 0 on reset.
//  Ports    : clk      in  system clock
//             rst      in  synchronous active-high reset
//             i_async  in  asynchronous input
//             o_sync   out synchronised copy, STAGES cycles late
//  Revision : 1.0 - initial release
// ============================================================================
module dj8v_cmp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift toward the MSB; bit 0 is the metastability-exposed stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_async};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q[STAGES-1];

endmodule : dj8v_cmp_sync
`default_nettype wire

// File: rtl/dj8v_sar_adc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dj8v_sar_adc_ctrl
//  Purpose  : Successive-approximation ADC controller. Drives trial codes on
//             the R2R ladder, reads the synchronised comparator and resolves
//             one bit per step, MSB first.
//  Ports    : clk       in  system clock
//             rst       in  synchronous active-high reset
//             start     in  single-cycle conversion request (ignored when busy)
//             cont      in  1 = restart automatically after each conversion
//             cmp_in    in  comparator output (Vin >= Vdac), asynchronous
//             dac_code  out registered code to the R2R ladder
//             busy      out conversion in progress
//             valid     out one-cycle pulse, result updated this cycle
//             result    out last completed conversion
//  Revision : 1.0 - initial release
// ============================================================================
module dj8v_sar_adc_ctrl
    import dj8v_adc_pkg::*;
#(
    parameter int WIDTH         = c_DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = c_DEFAULT_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = c_DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    // Each trial code must cover ladder settling plus the synchroniser delay
    // so the decision sees the comparator response to the current code.
    localparam int STEP_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
    localparam int CNT_W       = $clog2(STEP_CYCLES + 1);
    localparam int IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] c_STEP_RELOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_MSB     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MSB_TRIAL   = WIDTH'(1) << (WIDTH - 1);

    sar_state_e       state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] dac_q,    dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q,   busy_d;
    logic             valid_q,  valid_d;

    logic             w_cmp_sync;
    logic             w_restart;
    logic [WIDTH-1:0] w_committed;

    dj8v_cmp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_cmp_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (cmp_in),
        .o_sync  (w_cmp_sync)
    );

    assign w_restart = start | cont;

    // Current code with the bit under test replaced by the comparator verdict.
    always_comb begin
        w_committed        = dac_q;
        w_committed[idx_q] = w_cmp_sync;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dac_d    = dac_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                dac_d = result_q;
                if (w_restart) begin
                    state_d = CONV;
                    busy_d  = 1'b1;
                    idx_d   = c_IDX_MSB;
                    dac_d   = c_MSB_TRIAL;
                    cnt_d   = c_STEP_RELOAD;
                end
            end
            CONV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                    dac_d = w_committed | (WIDTH'(1) << (idx_q - IDX_W'(1)));
                    cnt_d = c_STEP_RELOAD;
                end else begin
                    result_d = w_committed;
                    valid_d  = 1'b1;
                    if (w_restart) begin
                        // Back-to-back conversion: no idle cycle in between.
                        idx_d = c_IDX_MSB;
                        dac_d = c_MSB_TRIAL;
                        cnt_d = c_STEP_RELOAD;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        dac_d   = w_committed;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= c_IDX_MSB;
            cnt_q    <= '0;
            dac_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign result   = result_q;

endmodule : dj8v_sar_adc_ctrl
`default_nettype wire

// File: tb/tb_dj8v_sar_adc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dj8v_sar_adc_ctrl
//  Purpose  : Self-checking bench for dj8v_sar_adc_ctrl. Instance 0 uses the
//             default parameters, instance 1 uses SETTLE_CYCLES=1 and
//             SYNC_STAGES=3. Each comparator is an ideal model of Vin >= Vdac.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dj8v_sar_adc_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] vin_s    [2];
    logic         start_s  [2];
    logic         cont_s   [2];
    logic         cmp_s    [2];
    logic [W-1:0] dac_s    [2];
    logic         busy_s   [2];
    logic         valid_s  [2];
    logic [W-1:0] result_s [2];

    // Reference: last result each instance should be holding.
    logic [W-1:0] exp_res [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cmp_s[0] = (vin_s[0] >= dac_s[0]);
    assign cmp_s[1] = (vin_s[1] >= dac_s[1]);

    dj8v_sar_adc_ctrl u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[0]),
        .cont     (cont_s[0]),
        .cmp_in   (cmp_s[0]),
        .dac_code (dac_s[0]),
        .busy     (busy_s[0]),
        .valid    (valid_s[0]),
        .result   (result_s[0])
    );

    dj8v_sar_adc_ctrl #(
        .WIDTH         (8),
        .SETTLE_CYCLES (1),
        .SYNC_STAGES   (3)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[1]),
        .cont     (cont_s[1]),
        .cmp_in   (cmp_s[1]),
        .dac_code (dac_s[1]),
        .busy     (busy_s[1]),
        .valid    (valid_s[1]),
        .result   (result_s[1])
    );

    function automatic int step_of(input int d);
        return (d == 0) ? 6 : 4;
    endfunction

    // k-th trial of a binary search for v: v's top k bits followed by a 1.
    function automatic logic [W-1:0] trial_code(input logic [W-1:0] v, input int k);
        logic [W-1:0] keep;
        logic [W-1:0] one;
        keep = 8'hFF;
        keep = keep << (W - k);
        one  = 8'h80;
        one  = one >> k;
        return (v & keep) | one;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dac_s[d] !== 8'h00) begin
                failures++;
                $display("FAIL reset_dac inst=%0d got=%h exp=00", d, dac_s[d]);
            end
            checks++;
            if (busy_s[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy inst=%0d got=%b exp=0", d, busy_s[d]);
            end
            checks++;
            if (valid_s[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid inst=%0d got=%b exp=0", d, valid_s[d]);
            end
            checks++;
            if (result_s[d] !== 8'h00) begin
                failures++;
                $display("FAIL reset_result inst=%0d got=%h exp=00", d, result_s[d]);
            end
            exp_res[d] = 8'h00;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Single start-initiated conversion; optional extra start pulse while busy.
    task automatic run_conv(input int d, input logic [W-1:0] v, input int second_start,
                            input string name);
        int           t;
        int           last;
        logic [W-1:0] exp_dac;
        logic         exp_busy;
        logic         exp_valid;
        t    = step_of(d);
        last = W * t;
        @(posedge clk);
        #1;
        vin_s[d]   = v;
        start_s[d] = 1'b1;
        for (int cyc = 0; cyc <= last + 2; cyc++) begin
            @(negedge clk);
            exp_busy  = (cyc >= 1) && (cyc <= last);
            exp_valid = (cyc == last + 1);
            if (cyc == 0)         exp_dac = exp_res[d];
            else if (cyc <= last) exp_dac = trial_code(v, (cyc - 1) / t);
            else                  exp_dac = v;
            if (cyc == last + 1)  exp_res[d] = v;
            checks++;
            if (dac_s[d] !== exp_dac) begin
                failures++;
                $display("FAIL %s_dac cyc=%0d got=%h exp=%h", name, cyc, dac_s[d], exp_dac);
            end
            checks++;
            if (busy_s[d] !== exp_busy) begin
                failures++;
                $display("FAIL %s_busy cyc=%0d got=%b exp=%b", name, cyc, busy_s[d], exp_busy);
            end
            checks++;
            if (valid_s[d] !== exp_valid) begin
                failures++;
                $display("FAIL %s_valid cyc=%0d got=%b exp=%b", name, cyc, valid_s[d], exp_valid);
            end
            checks++;
            if (result_s[d] !== exp_res[d]) begin
                failures++;
                $display("FAIL %s_result cyc=%0d got=%h exp=%h", name, cyc, result_s[d], exp_res[d]);
            end
            @(posedge clk);
            #1;
            start_s[d] = (cyc + 1 == second_start);
        end
    endtask

    task automatic test_single_a5();
        run_conv(0, 8'hA5, -1, "single_a5");
    endtask

    task automatic test_boundaries();
        run_conv(0, 8'h00, -1, "bound_00");
        run_conv(0, 8'hFF, -1, "bound_ff");
        run_conv(0, 8'h80, -1, "bound_80");
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        for (int i = 0; i < 4; i++) begin
            v = W'($urandom_range(0, 255));
            run_conv(0, v, -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_conv(0, 8'h6B, 20, "ignored_start");
    endtask

    // Continuous mode: two conversions with no idle gap, cont dropped mid-way
    // through the second one so the block finishes and goes idle.
    task automatic test_continuous();
        logic [W-1:0] v1;
        logic [W-1:0] v2;
        logic [W-1:0] exp_dac;
        logic         exp_busy;
        logic         exp_valid;
        v1 = 8'h10;
        v2 = 8'hEF;
        @(posedge clk);
        #1;
        vin_s[0]  = v1;
        cont_s[0] = 1'b1;
        for (int cyc = 0; cyc <= 98; cyc++) begin
            @(negedge clk);
            exp_busy  = (cyc >= 1) && (cyc <= 96);
            exp_valid = (cyc == 49) || (cyc == 97);
            if (cyc == 0)       exp_dac = exp_res[0];
            else if (cyc <= 48) exp_dac = trial_code(v1, (cyc - 1) / 6);
            else if (cyc <= 96) exp_dac = trial_code(v2, (cyc - 49) / 6);
            else                exp_dac = v2;
            if (cyc == 49) exp_res[0] = v1;
            if (cyc == 97) exp_res[0] = v2;
            checks++;
            if (dac_s[0] !== exp_dac) begin
                failures++;
                $display("FAIL cont_dac cyc=%0d got=%h exp=%h", cyc, dac_s[0], exp_dac);
            end
            checks++;
            if (busy_s[0] !== exp_busy) begin
                failures++;
                $display("FAIL cont_busy cyc=%0d got=%b exp=%b", cyc, busy_s[0], exp_busy);
            end
            checks++;
            if (valid_s[0] !== exp_valid) begin
                failures++;
                $display("FAIL cont_valid cyc=%0d got=%b exp=%b", cyc, valid_s[0], exp_valid);
            end
            checks++;
            if (result_s[0] !== exp_res[0]) begin
                failures++;
                $display("FAIL cont_result cyc=%0d got=%h exp=%h", cyc, result_s[0], exp_res[0]);
            end
            @(posedge clk);
            #1;
            if (cyc + 1 == 49) vin_s[0] = v2;
            if (cyc + 1 == 60) cont_s[0] = 1'b0;
        end
    endtask

    // Reset in cycle 25 of a conversion: everything clears, no valid follows.
    task automatic test_abort();
        logic [W-1:0] v;
        v = W'($urandom_range(1, 254));
        @(posedge clk);
        #1;
        vin_s[0]   = v;
        start_s[0] = 1'b1;
        for (int cyc = 0; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 26) begin
                checks++;
                if (dac_s[0] !== 8'h00) begin
                    failures++;
                    $display("FAIL abort_dac got=%h exp=00", dac_s[0]);
                end
                checks++;
                if (result_s[0] !== 8'h00) begin
                    failures++;
                    $display("FAIL abort_result got=%h exp=00", result_s[0]);
                end
            end
            if (cyc >= 26) begin
                checks++;
                if (busy_s[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_busy cyc=%0d got=%b exp=0", cyc, busy_s[0]);
                end
                checks++;
                if (valid_s[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_valid cyc=%0d got=%b exp=0", cyc, valid_s[0]);
                end
            end
            @(posedge clk);
            #1;
            start_s[0] = 1'b0;
            rst        = (cyc + 1 == 25);
        end
        exp_res[0] = 8'h00;
        exp_res[1] = 8'h00;
        run_conv(0, 8'h3C, -1, "after_abort");
    endtask

    task automatic test_short_step();
        run_conv(1, 8'h5A, -1, "short_5a");
        run_conv(1, W'($urandom_range(0, 255)), -1, "short_rand");
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vin_s[d]   = '0;
            start_s[d] = 1'b0;
            cont_s[d]  = 1'b0;
            exp_res[d] = '0;
        end
        test_reset();
        test_single_a5();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_continuous();
        test_abort();
        test_short_step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dj8v_sar_adc_ctrl
`default_nettype wire
